// File: rtl/demux_reg_bank.sv
// rtl/demux_reg_bank.sv - 16-entry write-decoded register bank with sequenced bulk clear
// Optional hardwired-zero entry 0 via DEMUX_REG_BANK_ZERO_REG_EN
module demux_reg_bank #(
    parameter int Length = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [Length-1:0] wr_data,
    input  logic              clr,
    output logic              busy,
    output logic [15:0]       written,
    output logic [Length-1:0] out0,
    output logic [Length-1:0] out1,
    output logic [Length-1:0] out2,
    output logic [Length-1:0] out3,
    output logic [Length-1:0] out4,
    output logic [Length-1:0] out5,
    output logic [Length-1:0] out6,
    output logic [Length-1:0] out7,
    output logic [Length-1:0] out8,
    output logic [Length-1:0] out9,
    output logic [Length-1:0] out10,
    output logic [Length-1:0] out11,
    output logic [Length-1:0] out12,
    output logic [Length-1:0] out13,
    output logic [Length-1:0] out14,
    output logic [Length-1:0] out15
);

`ifdef DEMUX_REG_BANK_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              wr_fire;
    logic              sweeping;
    logic [Length-1:0] entry [16];

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a clr seen while already sweeping is dropped
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr) state_next = CLEAR;
            CLEAR:   if (cnt == 4'd15) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:    wr_ready = 1'b1;
            CLEAR:   busy     = 1'b1;
            default: wr_ready = 1'b0;
        endcase
    end

    assign wr_fire  = wr_valid && wr_ready;
    assign sweeping = (state == CLEAR);

    // Sweep counter wraps from 15 back to 0 as the sweep ends
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= 4'd0;
        end else if (sweeping) begin
            cnt <= cnt + 4'd1;
        end else if (clr) begin
            cnt <= 4'd0;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_entry
        localparam logic [3:0] IDX = 4'(k);
        if (ZERO_REG && (k == 0)) begin : g_zero
            assign entry[k]   = '0;
            assign written[k] = 1'b0;
        end else begin : g_reg
            logic [Length-1:0] q;
            logic              w;
            logic              wr_hit;
            logic              clr_hit;

            assign wr_hit  = wr_fire && (wr_addr == IDX);
            assign clr_hit = sweeping && (cnt == IDX);

            // Writes and sweep never coincide since wr_ready is low while sweeping
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    q <= '0;
                    w <= 1'b0;
                end else if (clr_hit) begin
                    q <= '0;
                    w <= 1'b0;
                end else if (wr_hit) begin
                    q <= wr_data;
                    w <= 1'b1;
                end
            end

            assign entry[k]   = q;
            assign written[k] = w;
        end
    end

    assign out0  = entry[0];
    assign out1  = entry[1];
    assign out2  = entry[2];
    assign out3  = entry[3];
    assign out4  = entry[4];
    assign out5  = entry[5];
    assign out6  = entry[6];
    assign out7  = entry[7];
    assign out8  = entry[8];
    assign out9  = entry[9];
    assign out10 = entry[10];
    assign out11 = entry[11];
    assign out12 = entry[12];
    assign out13 = entry[13];
    assign out14 = entry[14];
    assign out15 = entry[15];

endmodule

// File: tb/tb_demux_reg_bank.sv
// tb/tb_demux_reg_bank.sv - self-checking bench for demux_reg_bank
module tb_demux_reg_bank;

`ifdef DEMUX_REG_BANK_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic        clr = 1'b0;
    logic        busy;
    logic [15:0] written;
    logic [31:0] dut_out [16];

    demux_reg_bank #(.Length(32)) dut (
        .clk(clk), .rstb(rstb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy), .written(written),
        .out0(dut_out[0]), .out1(dut_out[1]), .out2(dut_out[2]), .out3(dut_out[3]),
        .out4(dut_out[4]), .out5(dut_out[5]), .out6(dut_out[6]), .out7(dut_out[7]),
        .out8(dut_out[8]), .out9(dut_out[9]), .out10(dut_out[10]), .out11(dut_out[11]),
        .out12(dut_out[12]), .out13(dut_out[13]), .out14(dut_out[14]), .out15(dut_out[15])
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: array contents, flag word, and sweep position (-1 when idle)
    logic [31:0] m_out [16];
    logic [15:0] m_wr;
    int          m_sweep;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_out[i] = 32'd0;
        m_wr    = 16'd0;
        m_sweep = -1;
    endtask

    task automatic m_edge();
        if (m_sweep >= 0) begin
            m_out[m_sweep] = 32'd0;
            m_wr[m_sweep]  = 1'b0;
            m_sweep++;
            if (m_sweep == 16) m_sweep = -1;
        end else begin
            if (wr_valid && !(ZR && wr_addr == 4'd0)) begin
                m_out[wr_addr] = wr_data;
                m_wr[wr_addr]  = 1'b1;
            end
            if (clr) m_sweep = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " wr_ready"}, 32'(wr_ready), 32'(m_sweep < 0));
        chk({tag, " busy"}, 32'(busy), 32'(m_sweep >= 0));
        chk({tag, " written"}, 32'(written), 32'(m_wr));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s out%0d", tag, i), dut_out[i], m_out[i]);
    endtask

    typedef struct {
        bit          valid;
        logic [3:0]  addr;
        logic [31:0] data;
        bit          clr;
        bit          exp_ready;
        logic [15:0] exp_written;
        logic [3:0]  idx;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [15:0] acc;
        int          cnt;

        // Table: single write, idle cycle, then 16 back-to-back writes
        vt[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b1, 16'h0020, 4'd5, 32'hDEADBEEF};
        vt[1] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 16'h0020, 4'd4, 32'h0};
        acc = 16'h0020;
        for (int k = 0; k < 16; k++) begin
            if (!(ZR && k == 0)) acc[k] = 1'b1;
            vt[k + 2] = '{1'b1, 4'(k), 32'(k) * 32'h1111, 1'b0, 1'b1, acc, 4'(k),
                          (ZR && k == 0) ? 32'h0 : 32'(k) * 32'h1111};
        end

        // Power-up reset and release
        m_reset();
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        check_all("reset");

        // Asynchronous reset asserted mid-cycle after a write
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h55AA55AA;
        step();
        wr_valid = 1'b0;
        chk("pre_async out2", dut_out[2], 32'h55AA55AA);
        #3 rstb = 1'b0;
        #1;
        m_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 rstb = 1'b1;

        for (int i = 0; i < 18; i++) begin
            wr_valid = vt[i].valid; wr_addr = vt[i].addr;
            wr_data  = vt[i].data;  clr     = vt[i].clr;
            step();
            chk($sformatf("vec%0d ready", i), 32'(wr_ready), 32'(vt[i].exp_ready));
            chk($sformatf("vec%0d written", i), 32'(written), 32'(vt[i].exp_written));
            chk($sformatf("vec%0d out", i), dut_out[vt[i].idx], vt[i].exp_val);
            check_all($sformatf("vec%0d", i));
        end
        wr_valid = 1'b0;
        chk("full written", 32'(written), ZR ? 32'h0000FFFE : 32'h0000FFFF);

        // Full bank, clr pulse, held write to addr 3
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678;
        check_all("clr N");
        cnt = busy ? 1 : 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_all($sformatf("clr N+%0d", i));
            chk($sformatf("sweep zero%0d", i - 1), dut_out[i - 1], 32'h0);
            if (busy) cnt++;
        end
        chk("busy cycles", 32'(cnt), 32'd16);
        chk("held write pending", dut_out[3], 32'h0);
        step();
        wr_valid = 1'b0;
        chk("held write out3", dut_out[3], 32'h12345678);
        chk("held write written", 32'(written), 32'h00000008);
        check_all("clr N+17");

        // Write and clr together in IDLE
        wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 32'hA5A5A5A5; clr = 1'b1;
        step();
        wr_valid = 1'b0; clr = 1'b0;
        chk("wc out15", dut_out[15], 32'hA5A5A5A5);
        cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_all($sformatf("wc N+%0d", i));
            if (dut_out[15] == 32'hA5A5A5A5) cnt++;
        end
        chk("wc held cycles", 32'(cnt), 32'd15);
        chk("wc written15", 32'(written[15]), 32'd0);

        // Reset at sweep step 7
        for (int k = 1; k <= 4; k++) begin
            wr_valid = 1'b1; wr_addr = 4'(k + 8); wr_data = $urandom;
            step();
        end
        wr_valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        check_all("pre_abort");
        #3 rstb = 1'b0;
        #1;
        m_reset();
        check_all("abort_reset");
        @(posedge clk);
        #1 rstb = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 32'hCAFEF00D;
        step();
        wr_valid = 1'b0;
        chk("post_abort out9", dut_out[9], 32'hCAFEF00D);
        check_all("post_abort");

        // Randomized traffic against the model; inputs held while not ready
        for (int i = 0; i < 400; i++) begin
            if (wr_ready) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = 4'($urandom_range(0, 15));
                wr_data  = $urandom;
            end
            clr = ($urandom_range(0, 19) == 0);
            step();
            check_all($sformatf("rand%0d", i));
        end
        wr_valid = 1'b0; clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
